// File: rtl/adder_operand_sequencer.sv
// Operand sequencer for a ripple-carry adder. Debounced key presses capture A+cin and then B.
// After a settle delay it registers the adder's sum for display.
module adder_operand_sequencer #(
  parameter int bits            = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [bits-1:0]   sw_val,
  input  logic              sw_cin,
  input  logic              key_n,
  output logic [2*bits:0]   adder_in,
  input  logic [bits:0]     adder_sum,
  output logic [bits:0]     result,
  output logic              result_vld,
  output logic [1:0]        state_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    SETTLE = 2'b10,
    SHOW   = 2'b11
  } state_t;

  // Key path: the synchronizer idles at 1 because the button is active-low.
  logic          key_meta_q, key_sync_q;
  logic          deb_q;
  logic [DW-1:0] db_cnt_q;
  logic          press_q;
  logic          key_pressed;

  assign key_pressed = ~key_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
      deb_q      <= 1'b0;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
    end else begin
      key_meta_q <= key_n;
      key_sync_q <= key_meta_q;
      press_q    <= 1'b0;
      if (key_pressed != deb_q) begin
        if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q    <= key_pressed;
          db_cnt_q <= '0;
          press_q  <= key_pressed;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  // Operand/result FSM.
  state_t          state_q, state_d;
  logic [bits-1:0] op_a_q, op_a_d;
  logic [bits-1:0] op_b_q, op_b_d;
  logic            cin_q, cin_d;
  logic [bits:0]   result_q, result_d;
  logic            vld_q, vld_d;
  logic [SW-1:0]   settle_q, settle_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= WAIT_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      vld_q    <= 1'b0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      vld_q    <= vld_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    cin_d    = cin_q;
    result_d = result_q;
    vld_d    = vld_q;
    settle_d = settle_q;
    case (state_q)
      WAIT_A: begin
        if (press_q) begin
          op_a_d  = sw_val;
          cin_d   = sw_cin;
          vld_d   = 1'b0;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (press_q) begin
          op_b_d   = sw_val;
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        // Presses are deliberately ignored while the adder output settles.
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          result_d = adder_sum;
          vld_d    = 1'b1;
          state_d  = SHOW;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      SHOW: begin
        if (press_q) begin
          state_d = WAIT_A;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  assign adder_in   = {cin_q, op_a_q, op_b_q};
  assign result     = result_q;
  assign result_vld = vld_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Bench for adder_operand_sequencer: directed key/reset scenarios plus randomized operand runs.
// A behavioural adder closes the loop, and expected sums come from plain arithmetic on the chosen operands.
module tb_adder_operand_sequencer;

  localparam int D  = 4;
  localparam int SL = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw_val;
  logic       sw_cin;
  logic       key_n;
  logic [8:0] ain, ain_s;
  logic [4:0] sum, sum_s;
  logic [4:0] res, res_s;
  logic       vld, vld_s;
  logic [1:0] st, st_s;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [3:0] prev_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main unit under test, settle interval 2.
  adder_operand_sequencer #(.bits(4), .DEBOUNCE_CYCLES(D), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .sw_val(sw_val), .sw_cin(sw_cin), .key_n(key_n),
    .adder_in(ain), .adder_sum(sum), .result(res), .result_vld(vld), .state_o(st)
  );

  // Long-settle unit so a press can land inside SETTLE.
  adder_operand_sequencer #(.bits(4), .DEBOUNCE_CYCLES(D), .SETTLE_CYCLES(SL)) dut_s (
    .clk(clk), .reset(reset), .sw_val(sw_val), .sw_cin(sw_cin), .key_n(key_n),
    .adder_in(ain_s), .adder_sum(sum_s), .result(res_s), .result_vld(vld_s), .state_o(st_s)
  );

  // Behavioural stand-ins for the downstream ripple-carry adders.
  assign sum   = {1'b0, ain[7:4]}   + {1'b0, ain[3:0]}   + {4'b0, ain[8]};
  assign sum_s = {1'b0, ain_s[7:4]} + {1'b0, ain_s[3:0]} + {4'b0, ain_s[8]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press();
    key_n = 1'b0;
    repeat (D + 6) @(negedge clk);
    key_n = 1'b1;
    repeat (D + 6) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    prev_b = 4'd0;
    @(negedge clk);
  endtask

  task automatic run_op(input logic [3:0] a, input logic c, input logic [3:0] b);
    logic [4:0] exp_sum;
    exp_sum = {1'b0, a} + {1'b0, b} + {4'b0, c};
    sw_val = a;
    sw_cin = c;
    press();
    check("a_state", st, 2'b01);
    check("a_vld_drop", vld, 1'b0);
    check("a_adder_in", ain, {c, a, prev_b});
    sw_val = 4'($urandom);
    sw_cin = 1'($urandom);
    repeat (3) @(negedge clk);
    check("sw_move_hold", ain, {c, a, prev_b});
    sw_val = b;
    press();
    prev_b = b;
    check("b_state", st, 2'b11);
    check("b_adder_in", ain, {c, a, b});
    check("b_result", res, exp_sum);
    check("b_vld", vld, 1'b1);
    sw_val = 4'($urandom);
    press();
    check("show_exit_state", st, 2'b00);
    check("show_exit_vld", vld, 1'b1);
    check("show_exit_result", res, exp_sum);
    check("show_exit_adder_in", ain, {c, a, b});
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset  = 1'b1;
    key_n  = 1'b1;
    sw_val = 4'd0;
    sw_cin = 1'b0;
    prev_b = 4'd0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_state", st, 2'b00);
    check("rst_adder_in", ain, 9'h000);
    check("rst_result", res, 5'h00);
    check("rst_vld", vld, 1'b0);
    check("rst_state_s", st_s, 2'b00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic sum, then carry-out with and without carry-in.
    run_op(4'b0011, 1'b0, 4'b0101);
    check("t1_result", res, 5'b0_1000);
    run_op(4'b1111, 1'b1, 4'b0001);
    check("t2_carry_result", res, 5'b1_0001);
    run_op(4'b1111, 1'b0, 4'b0001);
    check("t2_nocin_result", res, 5'b1_0000);

    // Bouncy key: short glitches never register, a long hold gives one press, release gives none.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      key_n = 1'b0;
      repeat (2) @(negedge clk);
      key_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (D + 4) @(negedge clk);
    check("bounce_no_press", st, 2'b00);
    key_n = 1'b0;
    repeat (3 * D) @(negedge clk);
    check("hold_one_press", st, 2'b01);
    key_n = 1'b1;
    repeat (D + 6) @(negedge clk);
    check("release_no_press", st, 2'b01);

    // Exact settle latency, and a press arriving during SETTLE is swallowed.
    do_reset();
    sw_val = 4'd7;
    sw_cin = 1'b0;
    press();
    check("t4_a_state_s", st_s, 2'b01);
    sw_val = 4'd8;
    key_n  = 1'b0;
    for (int k = 0; k < 40 && st != 2'b10; k++) @(negedge clk);
    t0 = cyc;
    check("t4_b_capture", st, 2'b10);
    check("t4_b_capture_s", st_s, 2'b10);
    sw_val = 4'd3;
    @(negedge clk);
    check("t4_settle_1", st, 2'b10);
    check("t4_settle_adder_in", ain, {1'b0, 4'd7, 4'd8});
    @(negedge clk);
    check("t4_show_at_2", st, 2'b11);
    check("t4_result", res, 5'd15);
    key_n = 1'b1;
    repeat (D + 4) @(negedge clk);
    key_n = 1'b0;
    repeat (D + 4) @(negedge clk);
    check("t4_press_in_settle_s", st_s, 2'b10);
    for (int k = 0; k < 40 && st_s != 2'b11; k++) @(negedge clk);
    check("t4_settle_len_s", cyc - t0, SL);
    check("t4_result_s", res_s, 5'd15);
    check("t4_vld_s", vld_s, 1'b1);
    key_n = 1'b1;
    repeat (D + 6) @(negedge clk);
    check("t4_show_kept_s", st_s, 2'b11);

    // Reset abandons the operation in WAIT_B and in SHOW.
    do_reset();
    sw_val = 4'd9;
    sw_cin = 1'b1;
    press();
    check("t5_in_wait_b", st, 2'b01);
    reset = 1'b1;
    @(negedge clk);
    check("t5_wb_state", st, 2'b00);
    check("t5_wb_adder_in", ain, 9'h000);
    check("t5_wb_result", res, 5'h00);
    check("t5_wb_vld", vld, 1'b0);
    reset  = 1'b0;
    prev_b = 4'd0;
    @(negedge clk);
    sw_val = 4'd6;
    sw_cin = 1'b1;
    press();
    check("t5_recap_state", st, 2'b01);
    check("t5_recap_adder_in", ain, {1'b1, 4'd6, 4'd0});
    sw_val = 4'd2;
    press();
    check("t5_show_state", st, 2'b11);
    check("t5_show_result", res, 5'd9);
    reset = 1'b1;
    @(negedge clk);
    check("t5_sh_state", st, 2'b00);
    check("t5_sh_adder_in", ain, 9'h000);
    check("t5_sh_result", res, 5'h00);
    check("t5_sh_vld", vld, 1'b0);
    reset  = 1'b0;
    prev_b = 4'd0;
    @(negedge clk);
    run_op(4'd10, 1'b0, 4'd4);

    // Randomized operands against plain arithmetic.
    for (int i = 0; i < 200; i++) begin
      run_op(4'($urandom), 1'($urandom), 4'($urandom_range(15, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
